usb_hs_tx_serializer: RTL and testbench

//  USB2 high-speed transmit path, the outbound counterpart of the data recovery receive chain.

---
 rtl/usb_hs_pkg.sv | 30 +++
 rtl/usb_bit_stuff_nrzi.sv | 33 +++
 rtl/usb_hs_tx_serializer.sv | 173 +++++++++++++++++
 tb/tb_usb_hs_tx_serializer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_hs_pkg.sv
// usb_hs_pkg: shared state type, line-pattern constants and CRC16 helper
// for the USB2 high-speed transmit serializer.
package usb_hs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_CRC,
    ST_EOP
  } tx_state_t;

  localparam int SYNC_BITS_DEF = 32;
  localparam int EOP_BITS_DEF  = 8;
  localparam int STUFF_LEN_DEF = 6;

  localparam logic SYNC_FILL_BIT = 1'b0;
  localparam logic SYNC_END_BIT  = 1'b1;
  localparam logic EOP_HEAD_BIT  = 1'b0;
  localparam logic EOP_TAIL_BIT  = 1'b1;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_SEED = 16'hFFFF;

  // Non-reflected form: bit 15 of the register is the first bit on the wire.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_bit_stuff_nrzi.sv
// usb_bit_stuff_nrzi: run-length counter for bit stuffing and the NRZI line register.
// The caller substitutes the stuffed 0 whenever stall is high.
module usb_bit_stuff_nrzi #(
  parameter int STUFF_LEN = 6
) (
  input  logic clock_480,
  input  logic reset,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic bypass,
  output logic tx_line,
  output logic stall
);

  localparam int CW = $clog2(STUFF_LEN + 1);

  logic [CW-1:0] ones;

  always_ff @(posedge clock_480) begin
    if (reset || !bit_valid) begin
      ones    <= '0;
      tx_line <= 1'b1;
    end else begin
      tx_line <= bit_in ? tx_line : ~tx_line;
      if (bypass || !bit_in) ones <= '0;
      else                   ones <= ones + 1'b1;
    end
  end

  // ones counts the bit currently on the line, so stall describes the next bit time
  assign stall = (ones == CW'(STUFF_LEN));

endmodule

// File: rtl/usb_hs_tx_serializer.sv
// usb_hs_tx_serializer: USB2 HS transmit path (SYNC, stuffed NRZI payload, EOP).
// Optional CRC16 generation and CRC state enabled by the USB_TX_CRC16_EN macro.
//
// state | meaning
// IDLE  | line J, driver off, waiting for tx_valid
// SYNC  | sync pattern; first byte consumed on its last bit
// DATA  | byte sent LSB first; next byte consumed on bit 7
// CRC   | complemented CRC16, 16 bits (USB_TX_CRC16_EN only)
// EOP   | raw EOP pattern, stuffing bypassed
module usb_hs_tx_serializer
  import usb_hs_pkg::*;
#(
  parameter int SYNC_BITS = SYNC_BITS_DEF,
  parameter int EOP_BITS  = EOP_BITS_DEF,
  parameter int STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic       clock_480,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_line,
  output logic       tx_oe,
  output logic       tx_busy,
  output logic       underrun
);

  // All registers describe the bit currently on the line.
  tx_state_t  state, state_n;
  logic [5:0] cnt, cnt_n;
  logic [7:0] byte_q, nbyte;
  logic       stuff_q, stuff_n;
  logic       more_q, more_n;
  logic       last_q;
  logic       bit_n, valid_n, bypass_n;
  logic       stall;
  logic       sync_end, data_end, phase_end, consume_pt, take;

  assign sync_end   = (state == ST_SYNC) && (cnt == 6'(SYNC_BITS - 1));
  assign data_end   = (state == ST_DATA) && (cnt == 6'd7);
  assign phase_end  = sync_end || data_end || ((state == ST_CRC) && (cnt == 6'd15));
  assign consume_pt = sync_end || (data_end && !stuff_q);
  assign tx_ready   = consume_pt && !((state == ST_DATA) && last_q);
  assign take       = tx_ready && tx_valid;
  assign underrun   = tx_ready && !tx_valid;
  assign more_n     = consume_pt ? take : more_q;
  assign nbyte      = take ? tx_data : byte_q;
  assign tx_busy    = (state != ST_IDLE);

`ifdef USB_TX_CRC16_EN
  logic [15:0] crc, crc_nxt;
  logic        crc_q, tocrc_n, pid_q;

  assign tocrc_n = consume_pt ? ((state == ST_DATA) && last_q) : crc_q;
  assign crc_nxt = ((state == ST_DATA) && !stuff_q && !pid_q) ?
                   crc16_step(crc, byte_q[cnt[2:0]]) : crc;

  always_ff @(posedge clock_480) begin
    if (reset || state == ST_IDLE) begin
      crc   <= CRC16_SEED;
      crc_q <= 1'b0;
      pid_q <= 1'b0;
    end else begin
      crc <= crc_nxt;
      if (consume_pt) crc_q <= tocrc_n;
      if (take)       pid_q <= (state == ST_SYNC);
    end
  end
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    stuff_n  = 1'b0;
    bit_n    = 1'b1;
    valid_n  = 1'b1;
    bypass_n = 1'b0;
    case (state)
      ST_IDLE: begin
        valid_n = 1'b0;
        if (tx_valid) begin
          state_n = ST_SYNC;
          cnt_n   = '0;
          bit_n   = SYNC_FILL_BIT;
          valid_n = 1'b1;
        end
      end
      ST_SYNC, ST_DATA, ST_CRC: begin
        if (stall) begin
          bit_n   = 1'b0;
          stuff_n = 1'b1;
        end else if (phase_end) begin
          if (more_n) begin
            state_n = ST_DATA;
            cnt_n   = '0;
            bit_n   = nbyte[0];
          end
`ifdef USB_TX_CRC16_EN
          else if (tocrc_n && state != ST_CRC) begin
            state_n = ST_CRC;
            cnt_n   = '0;
            bit_n   = ~crc_nxt[15];
          end
`endif
          else begin
            state_n  = ST_EOP;
            cnt_n    = '0;
            bit_n    = EOP_HEAD_BIT;
            bypass_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 6'd1;
          case (state)
            ST_SYNC: bit_n = (cnt_n == 6'(SYNC_BITS - 1)) ? SYNC_END_BIT : SYNC_FILL_BIT;
            ST_DATA: bit_n = byte_q[cnt_n[2:0]];
`ifdef USB_TX_CRC16_EN
            ST_CRC:  bit_n = ~crc[~cnt_n[3:0]];
`endif
            default: bit_n = 1'b1;
          endcase
        end
      end
      ST_EOP: begin
        bypass_n = 1'b1;
        if (cnt == 6'(EOP_BITS - 1)) begin
          state_n = ST_IDLE;
          valid_n = 1'b0;
        end else begin
          cnt_n = cnt + 6'd1;
          bit_n = EOP_TAIL_BIT;
        end
      end
      default: begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_480) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      stuff_q <= 1'b0;
      more_q  <= 1'b0;
      last_q  <= 1'b0;
      byte_q  <= '0;
      tx_oe   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      stuff_q <= stuff_n;
      tx_oe   <= (state_n != ST_IDLE);
      if (consume_pt) more_q <= take;
      if (take) begin
        byte_q <= tx_data;
        last_q <= tx_last;
      end
    end
  end

  usb_bit_stuff_nrzi #(.STUFF_LEN(STUFF_LEN)) u_stuff (
    .clock_480 (clock_480),
    .reset     (reset),
    .bit_in    (bit_n),
    .bit_valid (valid_n),
    .bypass    (bypass_n),
    .tx_line   (tx_line),
    .stall     (stall)
  );

endmodule

// File: tb/tb_usb_hs_tx_serializer.sv
// tb_usb_hs_tx_serializer: packet-level reference model of the HS transmit line,
// compared against the serializer on every cycle, with directed and random packets.
module tb_usb_hs_tx_serializer;

  localparam int SYNC_BITS = 32;
  localparam int EOP_BITS  = 8;
  localparam int STUFF_LEN = 6;

  logic       clock_480 = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       tx_last   = 1'b0;
  logic       tx_ready, tx_line, tx_oe, tx_busy, underrun;

  usb_hs_tx_serializer dut (
    .clock_480 (clock_480),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .tx_line   (tx_line),
    .tx_oe     (tx_oe),
    .tx_busy   (tx_busy),
    .underrun  (underrun)
  );

  always #5 clock_480 = ~clock_480;

  typedef struct packed {
    logic line;
    logic oe;
    logic busy;
    logic ready;
    logic under;
  } exp_t;

  typedef logic [7:0] pkt_t [16];

  exp_t exp_q[$];
  bit   mbits[$];
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;
  int   ready_cnt = 0;
  int   under_cnt = 0;

  always @(negedge clock_480) begin
    exp_t e, a;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      a = '{tx_line, tx_oe, tx_busy, tx_ready, underrun};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t line/oe/busy/ready/under got=%b required=%b", $time, a, e);
      end
      if (tx_ready) ready_cnt++;
      if (underrun) under_cnt++;
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // Line-level model: pre-NRZI stream, stuffing, EOP, NRZI, plus handshake marks.
  task automatic build(input pkt_t pkt, input int n_sent, input bit has_last);
    bit pre[$], rdy[$], und[$], out[$], ordy[$], ound[$];
    int ones;
    logic l;
`ifdef USB_TX_CRC16_EN
    logic [15:0] crc;
    crc = 16'hFFFF;
`endif
    for (int i = 0; i < SYNC_BITS; i++) begin
      pre.push_back(i == SYNC_BITS - 1);
      rdy.push_back(i == SYNC_BITS - 1);
      und.push_back(1'b0);
    end
    for (int b = 0; b < n_sent; b++) begin
      for (int k = 0; k < 8; k++) begin
        pre.push_back(pkt[b][k]);
        rdy.push_back(k == 7 && !(b == n_sent - 1 && has_last));
        und.push_back(k == 7 && b == n_sent - 1 && !has_last);
`ifdef USB_TX_CRC16_EN
        if (b > 0) crc = (crc >> 1) ^ (((crc[0] ^ pkt[b][k]) != 1'b0) ? 16'hA001 : 16'h0000);
`endif
      end
    end
`ifdef USB_TX_CRC16_EN
    if (has_last)
      for (int k = 0; k < 16; k++) begin
        pre.push_back(~crc[k]);
        rdy.push_back(1'b0);
        und.push_back(1'b0);
      end
`endif
    ones = 0;
    for (int i = 0; i < pre.size(); i++) begin
      out.push_back(pre[i]);
      ordy.push_back(rdy[i]);
      ound.push_back(und[i]);
      ones = pre[i] ? ones + 1 : 0;
      if (ones == STUFF_LEN) begin
        out.push_back(1'b0);
        ordy.push_back(1'b0);
        ound.push_back(1'b0);
        ones = 0;
      end
    end
    for (int i = 0; i < EOP_BITS; i++) begin
      out.push_back(i != 0);
      ordy.push_back(1'b0);
      ound.push_back(1'b0);
    end
    mbits = {};
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    l = 1'b1;
    for (int i = 0; i < out.size(); i++) begin
      if (!out[i]) l = ~l;
      exp_q.push_back('{l, 1'b1, 1'b1, ordy[i], ound[i]});
      mbits.push_back(out[i]);
    end
  endtask

  task automatic send(input pkt_t pkt, input int n_sent, input bit has_last,
                      input bit b2b, input int gap);
    int guard, idx;
    bit hs;
    guard = 0;
    if (b2b) begin
      while (exp_q.size() > 1 && guard < 5000) begin
        @(posedge clock_480); #1; guard++;
      end
    end else begin
      while (exp_q.size() > 0 && guard < 5000) begin
        @(posedge clock_480); #1; guard++;
      end
      repeat (gap) begin @(posedge clock_480); #1; end
    end
    if (guard >= 5000) check("send_wait_timeout", guard, 0);
    build(pkt, n_sent, has_last);
    idx      = 0;
    tx_data  = pkt[0];
    tx_last  = has_last && n_sent == 1;
    tx_valid = 1'b1;
    guard    = 0;
    while (idx < n_sent && guard < 5000) begin
      @(negedge clock_480);
      hs = tx_valid && tx_ready;
      @(posedge clock_480); #1;
      guard++;
      if (hs) begin
        idx++;
        if (idx < n_sent) begin
          tx_data = pkt[idx];
          tx_last = has_last && idx == n_sent - 1;
        end else begin
          tx_valid = 1'b0;
          tx_last  = 1'b0;
          tx_data  = 8'($urandom);
        end
      end
    end
    if (guard >= 5000) begin
      check("handshake_timeout", idx, n_sent);
      tx_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 5000) begin
      @(posedge clock_480); #1; g++;
    end
    check("drain_done", int'(g < 5000), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t pkt;
    int   n, ncrc;
    bit   und, b2b;
    int   zero_or;

`ifdef USB_TX_CRC16_EN
    ncrc = 16;
`else
    ncrc = 0;
`endif
    for (int i = 0; i < 16; i++) pkt[i] = 8'h00;

    repeat (3) @(posedge clock_480);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (20) @(posedge clock_480);
    #1 check("idle_ready_cnt", ready_cnt, 0);

    pkt[0] = 8'h00;
    send(pkt, 1, 1'b1, 1'b0, 0);
    check("len_byte00", mbits.size(), SYNC_BITS + 8 + ncrc + EOP_BITS);
    check("sync_first_bit", int'(mbits[0]), 0);
    check("sync_last_bit", int'(mbits[SYNC_BITS - 1]), 1);
    drain();

    pkt[0] = 8'hFF;
    send(pkt, 1, 1'b1, 1'b0, 2);
    check("len_byteFF", mbits.size(), SYNC_BITS + 9 + ncrc + EOP_BITS);
    check("stuff_pos_FF", int'(mbits[SYNC_BITS + 5]), 0);
    drain();

    pkt[0] = 8'hC3; pkt[1] = 8'h12; pkt[2] = 8'h34;
    ready_cnt = 0;
    send(pkt, 3, 1'b1, 1'b0, 1);
    drain();
    check("ready_pulses_3", ready_cnt, 3);

    under_cnt = 0;
    send(pkt, 1, 1'b0, 1'b0, 1);
    drain();
    check("underrun_pulses", under_cnt, 1);
    check("busy_after_underrun", int'(tx_busy), 0);

`ifdef USB_TX_CRC16_EN
    pkt[0] = 8'hC3;
    send(pkt, 1, 1'b1, 1'b0, 1);
    zero_or = 0;
    for (int k = 0; k < 16; k++) zero_or = zero_or | int'(mbits[SYNC_BITS + 8 + k]);
    check("crc_empty_zero", zero_or, 0);
    drain();
`endif

    // back-to-back: next tx_valid raised during the last EOP bit
    pkt[0] = 8'h5A; pkt[1] = 8'hFF;
    send(pkt, 2, 1'b1, 1'b0, 0);
    pkt[0] = 8'h3C;
    send(pkt, 1, 1'b1, 1'b1, 0);
    drain();

    // reset in the middle of DATA
    tx_data = 8'hA5; tx_last = 1'b0; tx_valid = 1'b1;
    chk_en = 1'b0;
    repeat (40) @(posedge clock_480);
    #1 check("oe_before_reset", int'(tx_oe), 1);
    reset = 1'b1; tx_valid = 1'b0;
    @(posedge clock_480); #1;
    check("reset_oe", int'(tx_oe), 0);
    check("reset_line", int'(tx_line), 1);
    check("reset_busy", int'(tx_busy), 0);
    reset = 1'b0;
    exp_q = {};
    chk_en = 1'b1;
    pkt[0] = 8'h69; pkt[1] = 8'h7E;
    send(pkt, 2, 1'b1, 1'b0, 1);
    drain();

    for (int p = 0; p < 25; p++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        pkt[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      und = ($urandom_range(0, 4) == 0);
      b2b = ($urandom_range(0, 1) == 1);
      send(pkt, n, !und, b2b, $urandom_range(0, 3));
    end
    drain();
    repeat (5) @(posedge clock_480);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
